// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, sends a start bit, eight
// data bits LSB first, odd parity and stop, then checks the device ACK.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 2500,
  parameter int unsigned TIMEOUT_CYCLES = 375000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_START,
    ST_BITS,
    ST_ACK,
    ST_WAIT_IDLE
  } state_t;

  logic             clk_meta, clk_sync, data_meta, data_sync;
  logic             clk_filt, fall;
  logic [FLT_W-1:0] flt_cnt;

  state_t           state_q, state_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic [8:0]       shift_q, shift_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             ready_q, busy_q;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             timeout_c;

  // Pin synchronizers, glitch filter on the clock and registered fall strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
      clk_filt  <= 1'b1;
      flt_cnt   <= '0;
      fall      <= 1'b0;
    end else begin
      clk_meta  <= ps2_clk_in;
      clk_sync  <= clk_meta;
      data_meta <= ps2_data_in;
      data_sync <= data_meta;
      fall      <= 1'b0;
      if (clk_sync != clk_filt) begin
        if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
          clk_filt <= clk_sync;
          flt_cnt  <= '0;
          fall     <= clk_filt & ~clk_sync;
        end else begin
          flt_cnt <= flt_cnt + 1'b1;
        end
      end else begin
        flt_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      inh_cnt_q <= '0;
      to_cnt_q  <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      inh_cnt_q <= inh_cnt_d;
      to_cnt_q  <= to_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      ready_q   <= (state_d == ST_IDLE);
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  // Next-state and next-output logic; timeout wins over a clock fall
  always_comb begin
    state_d   = state_q;
    inh_cnt_d = inh_cnt_q;
    to_cnt_d  = to_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    clk_oe_d  = 1'b0;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    timeout_c = (to_cnt_q == '0);

    case (state_q)
      ST_IDLE: begin
        data_oe_d = 1'b0;
        if (tx_valid) begin
          shift_d   = {~^tx_data, tx_data};
          inh_cnt_d = INH_W'(INHIBIT_CYCLES - 1);
          clk_oe_d  = 1'b1;
          state_d   = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        clk_oe_d  = 1'b1;
        data_oe_d = 1'b0;
        if (inh_cnt_q == '0) begin
          data_oe_d = 1'b1;
          state_d   = ST_START;
        end else begin
          inh_cnt_d = inh_cnt_q - 1'b1;
        end
      end
      ST_START: begin
        data_oe_d = 1'b1;
        bit_idx_d = '0;
        to_cnt_d  = TO_W'(TIMEOUT_CYCLES - 1);
        state_d   = ST_BITS;
      end
      ST_BITS: begin
        to_cnt_d = to_cnt_q - 1'b1;
        if (timeout_c) begin
          data_oe_d = 1'b0;
          error_d   = 1'b1;
          state_d   = ST_IDLE;
        end else if (fall) begin
          if (bit_idx_q == 4'd9) begin
            data_oe_d = 1'b0;
            state_d   = ST_ACK;
          end else begin
            data_oe_d = ~shift_q[0];
            shift_d   = {1'b0, shift_q[8:1]};
          end
          bit_idx_d = bit_idx_q + 4'd1;
        end
      end
      ST_ACK: begin
        to_cnt_d  = to_cnt_q - 1'b1;
        data_oe_d = 1'b0;
        if (timeout_c) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else if (fall) begin
          if (!data_sync) begin
            state_d = ST_WAIT_IDLE;
          end else begin
            error_d = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        to_cnt_d  = to_cnt_q - 1'b1;
        data_oe_d = 1'b0;
        if (timeout_c) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else if (clk_sync && data_sync) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        data_oe_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  assign tx_ready    = ready_q;
  assign tx_busy     = busy_q;
  assign tx_done     = done_q;
  assign tx_error    = error_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule
